id_decode_stage: RTL and testbench

Registered RISC-V RV32I/RV64I instruction-decode stage. It replaces the purely combinational decoder with the following:
- a valid/ready handshake to IF and EX;
- an ID/EX output register holding the decoded control bundle and sign-extended immediate;
- a load-use interlock;
- branch-flush handling;
- optional CSR and M-extension decode.

It sits between the IF/ID register and the EX stage.

---
 rtl/id_decode_stage_pkg.sv | 75 +++++++
 rtl/id_decode_stage_imm_gen.sv | 51 +++++
 rtl/id_decode_stage.sv | 211 +++++++++++++++++++++
 tb/tb_id_decode_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode_stage_pkg
//  Description : Shared opcode/funct constants, store-width encodings and the
//                decoded control bundle carried by the ID/EX register.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_decode_stage_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Store widths
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Unsigned load widths
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // SYSTEM funct3: 000 is ECALL/EBREAK/xRET, everything else is a CSR op
    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // funct7 selecting the M extension inside OP
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Store-width encoding presented to EX
    localparam logic [1:0] WRITE_IDLE = 2'b00;
    localparam logic [1:0] WRITE_BYTE = 2'b01;
    localparam logic [1:0] WRITE_HALF = 2'b10;
    localparam logic [1:0] WRITE_WORD = 2'b11;

    // Decoded control bundle (everything except PC and immediate)
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        branch;
        logic        memread;
        logic        memtoreg;
        logic        alusrc;
        logic        regwrite;
        logic [1:0]  memwrite;
        logic        load_unsigned;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic        is_muldiv;
        logic        illegal;
    } ctrl_t;

    // Formats that carry a real rs2 field (R, S, B)
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode_stage_imm_gen
//  Description : Immediate generator. Picks the I/S/B/U/J layout from the
//                opcode and sign-extends bit 31 to XLEN. R-type and unknown
//                opcodes produce zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_decode_stage_imm_gen
    import id_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the instruction's format
    always_comb begin
        imm32 = '0;
        case (i_instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            OPC_STORE:
                imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {i_instr[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // Widen to XLEN by replicating the sign bit on RV64
    generate
        if (XLEN > 32) begin : g_sext
            assign o_imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_native
            assign o_imm = imm32[XLEN-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode_stage
//  Description : Registered RV32I/RV64I decode stage with IF/EX valid-ready
//                handshake, load-use interlock, branch flush and optional
//                CSR / M-extension decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_CSR = 1'b1,
    parameter bit EN_M   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_branch,
    output logic            out_memread,
    output logic            out_memtoreg,
    output logic            out_alusrc,
    output logic            out_regwrite,
    output logic [1:0]      out_memwrite,
    output logic            out_load_unsigned,
    output logic            out_csr_we,
    output logic [11:0]     out_csr_addr,
    output logic            out_is_muldiv,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_dec;
    ctrl_t           dec;

    logic            stall;
    logic            advance;
    logic            accept;

    logic            valid_q, valid_d;
    ctrl_t           ctrl_q,  ctrl_d;
    logic [XLEN-1:0] imm_q,   imm_d;
    logic [XLEN-1:0] pc_q,    pc_d;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    id_decode_stage_imm_gen #(
        .XLEN    (XLEN)
    ) u_imm_gen (
        .i_instr (in_instr),
        .o_imm   (imm_dec)
    );

    // Combinational decode of the incoming instruction into the control bundle
    always_comb begin
        dec        = '0;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.rd     = rd;
        dec.funct3 = funct3;
        dec.funct7 = funct7;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.branch   = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.alusrc = 1'b1;
            end
            OPC_LOAD: begin
                dec.memread       = 1'b1;
                dec.memtoreg      = 1'b1;
                dec.alusrc        = 1'b1;
                dec.regwrite      = 1'b1;
                dec.load_unsigned = (funct3 == F3_LBU) || (funct3 == F3_LHU);
            end
            OPC_STORE: begin
                dec.alusrc = 1'b1;
                case (funct3)
                    F3_SB:   dec.memwrite = WRITE_BYTE;
                    F3_SH:   dec.memwrite = WRITE_HALF;
                    F3_SW:   dec.memwrite = WRITE_WORD;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_MULDIV) begin
                    // M-extension encoding: legal only when the unit exists
                    if (EN_M) begin
                        dec.is_muldiv = 1'b1;
                        dec.regwrite  = 1'b1;
                    end else begin
                        dec.illegal   = 1'b1;
                    end
                end else begin
                    dec.regwrite = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (!EN_CSR) begin
                    dec.illegal = 1'b1;
                end else if (funct3 != F3_PRIV) begin
                    dec.csr_addr = in_instr[31:20];
                    // Set/clear with a zero source never modifies the CSR
                    dec.csr_we   = !(((funct3 == F3_CSRRS)  || (funct3 == F3_CSRRC) ||
                                      (funct3 == F3_CSRRSI) || (funct3 == F3_CSRRCI)) &&
                                     (rs1 == 5'd0));
                    dec.regwrite = (rd != 5'd0);
                end
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Load-use interlock and handshake qualifiers
    always_comb begin
        stall    = in_valid && ex_memread && (ex_rd != 5'd0) &&
                   ((ex_rd == rs1) || (uses_rs2(opcode) && (ex_rd == rs2)));
        advance  = !valid_q || out_ready;
        in_ready = !rst && advance && !stall && !flush;
        accept   = in_valid && in_ready;
    end

    // Next state of the ID/EX register: flush kills, stall inserts a bubble
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            valid_d = accept;
            if (accept) begin
                ctrl_d = dec;
                imm_d  = imm_dec;
                pc_d   = in_pc;
            end
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid         = valid_q;
    assign out_pc            = pc_q;
    assign out_imm           = imm_q;
    assign out_rs1           = ctrl_q.rs1;
    assign out_rs2           = ctrl_q.rs2;
    assign out_rd            = ctrl_q.rd;
    assign out_funct3        = ctrl_q.funct3;
    assign out_funct7        = ctrl_q.funct7;
    assign out_branch        = ctrl_q.branch;
    assign out_memread       = ctrl_q.memread;
    assign out_memtoreg      = ctrl_q.memtoreg;
    assign out_alusrc        = ctrl_q.alusrc;
    assign out_regwrite      = ctrl_q.regwrite;
    assign out_memwrite      = ctrl_q.memwrite;
    assign out_load_unsigned = ctrl_q.load_unsigned;
    assign out_csr_we        = ctrl_q.csr_we;
    assign out_csr_addr      = ctrl_q.csr_addr;
    assign out_is_muldiv     = ctrl_q.is_muldiv;
    assign out_illegal       = ctrl_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_decode_stage
//  Description : Self-checking bench. Two decoders share the stimulus:
//                A = RV32, CSR on, M off;  B = RV64, CSR off, M on.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, ex_memread, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic [4:0]  ex_rd;

    logic        a_in_ready, a_out_valid, a_branch, a_memread, a_memtoreg, a_alusrc, a_regwrite;
    logic        a_lu, a_csr_we, a_muldiv, a_illegal;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;
    logic [1:0]  a_memwrite;
    logic [11:0] a_csr_addr;

    logic        b_in_ready, b_out_valid, b_branch, b_memread, b_memtoreg, b_alusrc, b_regwrite;
    logic        b_lu, b_csr_we, b_muldiv, b_illegal;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;
    logic [1:0]  b_memwrite;
    logic [11:0] b_csr_addr;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        branch, memread, memtoreg, alusrc, regwrite;
        logic [1:0]  memwrite;
        logic        lu, csr_we;
        logic [11:0] csr_addr;
        logic        muldiv, illegal;
    } obs_t;

    obs_t exp_a = '0;
    obs_t exp_b = '0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [6:0] ops [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                               7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
    logic [2:0] sys_f3 [0:6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    always #5 clk = ~clk;

    id_decode_stage #(.XLEN(32), .EN_CSR(1'b1), .EN_M(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_rd(a_rd), .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm),
        .out_branch(a_branch), .out_memread(a_memread), .out_memtoreg(a_memtoreg),
        .out_alusrc(a_alusrc), .out_regwrite(a_regwrite), .out_memwrite(a_memwrite),
        .out_load_unsigned(a_lu), .out_csr_we(a_csr_we), .out_csr_addr(a_csr_addr),
        .out_is_muldiv(a_muldiv), .out_illegal(a_illegal)
    );

    id_decode_stage #(.XLEN(64), .EN_CSR(1'b0), .EN_M(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_rd(b_rd), .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm),
        .out_branch(b_branch), .out_memread(b_memread), .out_memtoreg(b_memtoreg),
        .out_alusrc(b_alusrc), .out_regwrite(b_regwrite), .out_memwrite(b_memwrite),
        .out_load_unsigned(b_lu), .out_csr_we(b_csr_we), .out_csr_addr(b_csr_addr),
        .out_is_muldiv(b_muldiv), .out_illegal(b_illegal)
    );

    function automatic obs_t obs_a();
        obs_t o;
        o = '0;
        o.valid = a_out_valid; o.pc = {32'h0, a_pc}; o.rs1 = a_rs1; o.rs2 = a_rs2; o.rd = a_rd;
        o.f3 = a_f3; o.f7 = a_f7; o.imm = {32'h0, a_imm}; o.branch = a_branch;
        o.memread = a_memread; o.memtoreg = a_memtoreg; o.alusrc = a_alusrc;
        o.regwrite = a_regwrite; o.memwrite = a_memwrite; o.lu = a_lu; o.csr_we = a_csr_we;
        o.csr_addr = a_csr_addr; o.muldiv = a_muldiv; o.illegal = a_illegal;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '0;
        o.valid = b_out_valid; o.pc = b_pc; o.rs1 = b_rs1; o.rs2 = b_rs2; o.rd = b_rd;
        o.f3 = b_f3; o.f7 = b_f7; o.imm = b_imm; o.branch = b_branch;
        o.memread = b_memread; o.memtoreg = b_memtoreg; o.alusrc = b_alusrc;
        o.regwrite = b_regwrite; o.memwrite = b_memwrite; o.lu = b_lu; o.csr_we = b_csr_we;
        o.csr_addr = b_csr_addr; o.muldiv = b_muldiv; o.illegal = b_illegal;
        return o;
    endfunction

    // Reference decode: immediates rebuilt with signed arithmetic, controls from the class table
    function automatic obs_t model_decode(input logic [31:0] w, input logic [63:0] pc,
                                          input bit wide, input bit en_csr, input bit en_m);
        obs_t   e;
        int     op, f3, f7, top, sgn, simm;
        longint limm;
        e   = '0;
        op  = int'(w[6:0]);
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        top = $signed(w) >>> 20;
        sgn = $signed(w) >>> 31;
        case (op)
            'h13, 'h03, 'h67: simm = top;
            'h23:             simm = (top & ~31) | int'(w[11:7]);
            'h63:             simm = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            'h37, 'h17:       simm = int'(w & 32'hFFFF_F000);
            'h6F:             simm = sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default:          simm = 0;
        endcase
        limm    = simm;
        e.imm   = wide ? limm : {32'h0, simm};
        e.valid = 1'b1;
        e.pc    = wide ? pc : {32'h0, pc[31:0]};
        e.rs1   = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.f3    = w[14:12]; e.f7 = w[31:25];
        case (op)
            'h37, 'h17, 'h13: begin e.alusrc = 1; e.regwrite = 1; end
            'h6F, 'h67:       begin e.branch = 1; e.alusrc = 1; e.regwrite = 1; end
            'h63:             begin e.branch = 1; e.alusrc = 1; end
            'h03: begin
                e.memread = 1; e.memtoreg = 1; e.alusrc = 1; e.regwrite = 1;
                e.lu = (f3 == 4) || (f3 == 5);
            end
            'h23: begin
                e.alusrc = 1;
                if (f3 <= 2) e.memwrite = 2'(f3 + 1);
                else         e.illegal  = 1;
            end
            'h33: begin
                if (f7 == 1) begin
                    if (en_m) begin e.muldiv = 1; e.regwrite = 1; end
                    else      e.illegal = 1;
                end else begin
                    e.regwrite = 1;
                end
            end
            'h73: begin
                if (!en_csr) begin
                    e.illegal = 1;
                end else if (f3 != 0) begin
                    e.csr_addr = w[31:20];
                    e.csr_we   = !(((f3 & 3) >= 2) && (w[19:15] == 5'd0));
                    e.regwrite = (w[11:7] != 5'd0);
                end
            end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic bit model_stall();
        bit r2;
        r2 = (in_instr[6:0] == 7'h33) || (in_instr[6:0] == 7'h23) || (in_instr[6:0] == 7'h63);
        return in_valid && ex_memread && (ex_rd != 5'd0) &&
               ((ex_rd == in_instr[19:15]) || (r2 && (ex_rd == in_instr[24:20])));
    endfunction

    function automatic bit model_ready();
        return !rst && (!exp_a.valid || out_ready) && !model_stall() && !flush;
    endfunction

    // Advance one clock and move the expected ID/EX contents along with it
    task automatic tick();
        obs_t na, nb;
        na = exp_a;
        nb = exp_b;
        if (rst) begin
            na = '0; nb = '0;
        end else if (flush) begin
            na.valid = 0; nb.valid = 0;
        end else if (!exp_a.valid || out_ready) begin
            if (in_valid && !model_stall()) begin
                na = model_decode(in_instr, in_pc, 1'b0, 1'b1, 1'b0);
                nb = model_decode(in_instr, in_pc, 1'b1, 1'b0, 1'b1);
            end else begin
                na.valid = 0; nb.valid = 0;
            end
        end
        @(posedge clk);
        #1;
        exp_a = na;
        exp_b = nb;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; in_instr = 32'h00A00093; in_pc = 64'h100;
        flush = 0; ex_memread = 0; ex_rd = 0; out_ready = 1;
        tick(); tick();
        n_tests++; if (obs_a() !== obs_t'(0)) begin n_fail++; $display("FAIL reset_a got=%h exp=0", obs_a()); end
        n_tests++; if (obs_b() !== obs_t'(0)) begin n_fail++; $display("FAIL reset_b got=%h exp=0", obs_b()); end
        n_tests++; if ({a_in_ready, b_in_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_in_ready got=%b%b exp=00", a_in_ready, b_in_ready); end
        rst = 0; in_valid = 0;
        #1;
        n_tests++; if ({a_in_ready, b_in_ready} !== 2'b11) begin n_fail++; $display("FAIL post_reset_in_ready got=%b%b exp=11", a_in_ready, b_in_ready); end
    endtask

    task automatic test_alu_imm();
        in_valid = 1; in_instr = 32'h00A00093; in_pc = 64'h104; out_ready = 1;
        tick();
        in_valid = 0;
        n_tests++; if ({a_out_valid, a_rd, a_alusrc, a_regwrite, a_memwrite} !== {1'b1, 5'd1, 1'b1, 1'b1, 2'b00})
            begin n_fail++; $display("FAIL addi_ctrl got v=%b rd=%0d as=%b rw=%b mw=%b", a_out_valid, a_rd, a_alusrc, a_regwrite, a_memwrite); end
        n_tests++; if (a_imm !== 32'd10) begin n_fail++; $display("FAIL addi_imm got=%h exp=0000000a", a_imm); end
        n_tests++; if (obs_a() !== exp_a) begin n_fail++; $display("FAIL addi_a got=%h exp=%h", obs_a(), exp_a); end
        in_valid = 1; in_instr = 32'hFFF00093;
        tick();
        in_valid = 0;
        n_tests++; if ({a_imm, b_imm} !== {32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF})
            begin n_fail++; $display("FAIL neg_imm got a=%h b=%h exp all ones", a_imm, b_imm); end
        n_tests++; if (obs_b() !== exp_b) begin n_fail++; $display("FAIL neg_imm_b got=%h exp=%h", obs_b(), exp_b); end
    endtask

    task automatic test_load_store();
        in_valid = 1; in_instr = 32'h00012283; in_pc = 64'h108; out_ready = 1;
        tick();
        n_tests++; if ({a_out_valid, a_memread, a_memtoreg, a_rd} !== {1'b1, 1'b1, 1'b1, 5'd5})
            begin n_fail++; $display("FAIL lw_ctrl got v=%b mr=%b mtr=%b rd=%0d", a_out_valid, a_memread, a_memtoreg, a_rd); end
        in_instr = 32'h00512223; in_pc = 64'h10C;
        tick();
        in_valid = 0;
        n_tests++; if ({a_memwrite, a_regwrite, a_memread, a_imm} !== {2'b11, 1'b0, 1'b0, 32'd4})
            begin n_fail++; $display("FAIL sw_ctrl got mw=%b rw=%b mr=%b imm=%h", a_memwrite, a_regwrite, a_memread, a_imm); end
        n_tests++; if (obs_a() !== exp_a) begin n_fail++; $display("FAIL sw_a got=%h exp=%h", obs_a(), exp_a); end
        in_valid = 1; in_instr = 32'h00513223;
        tick();
        in_valid = 0;
        n_tests++; if ({a_memwrite, a_illegal} !== {2'b00, 1'b1})
            begin n_fail++; $display("FAIL bad_store got mw=%b ill=%b exp mw=00 ill=1", a_memwrite, a_illegal); end
    endtask

    task automatic test_load_use();
        in_valid = 1; in_instr = 32'h00128333; in_pc = 64'h110; out_ready = 1;
        ex_memread = 1; ex_rd = 5;
        #1;
        n_tests++; if ({a_in_ready, b_in_ready} !== 2'b00) begin n_fail++; $display("FAIL stall_in_ready got=%b%b exp=00", a_in_ready, b_in_ready); end
        tick();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble got valid=%b exp=0", a_out_valid); end
        n_tests++; if (obs_a() !== exp_a) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", obs_a(), exp_a); end
        ex_memread = 0;
        #1;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL unstall_in_ready got=%b exp=1", a_in_ready); end
        tick();
        in_valid = 0;
        n_tests++; if ({a_out_valid, a_rd} !== {1'b1, 5'd6}) begin n_fail++; $display("FAIL unstall_add got v=%b rd=%0d exp v=1 rd=6", a_out_valid, a_rd); end
    endtask

    task automatic test_backpressure_flush();
        obs_t snap;
        in_valid = 1; in_instr = 32'h00A00093; in_pc = 64'h114; out_ready = 1;
        tick();
        snap = obs_a();
        out_ready = 0; in_instr = 32'h00012283; in_pc = 64'h118;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, a_in_ready); end
            tick();
            n_tests++; if (obs_a() !== snap || obs_a() !== exp_a) begin n_fail++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, obs_a(), snap); end
        end
        flush = 1;
        #1;
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", a_in_ready); end
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        n_tests++; if ({a_out_valid, b_out_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_valid got=%b%b exp=00", a_out_valid, b_out_valid); end
        n_tests++; if (obs_a() !== exp_a) begin n_fail++; $display("FAIL flush_a got=%h exp=%h", obs_a(), exp_a); end
    endtask

    task automatic test_csr_muldiv();
        in_valid = 1; in_instr = 32'h300110F3; in_pc = 64'h11C; out_ready = 1;
        tick();
        n_tests++; if ({a_csr_we, a_csr_addr, a_regwrite, a_illegal} !== {1'b1, 12'h300, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL csrrw_a got we=%b addr=%h rw=%b ill=%b", a_csr_we, a_csr_addr, a_regwrite, a_illegal); end
        n_tests++; if ({b_illegal, b_csr_we} !== 2'b10) begin n_fail++; $display("FAIL csrrw_nocsr got ill=%b we=%b exp ill=1 we=0", b_illegal, b_csr_we); end
        in_instr = 32'h300020F3;
        tick();
        n_tests++; if ({a_csr_we, a_regwrite} !== 2'b01) begin n_fail++; $display("FAIL csrrs_x0 got we=%b rw=%b exp we=0 rw=1", a_csr_we, a_regwrite); end
        in_instr = 32'h022081B3;
        tick();
        in_valid = 0;
        n_tests++; if ({a_illegal, a_muldiv, a_regwrite} !== 3'b100) begin n_fail++; $display("FAIL mul_no_m got ill=%b md=%b rw=%b exp 100", a_illegal, a_muldiv, a_regwrite); end
        n_tests++; if ({b_illegal, b_muldiv, b_regwrite} !== 3'b011) begin n_fail++; $display("FAIL mul_m got ill=%b md=%b rw=%b exp 011", b_illegal, b_muldiv, b_regwrite); end
        n_tests++; if (obs_b() !== exp_b) begin n_fail++; $display("FAIL mul_b got=%h exp=%h", obs_b(), exp_b); end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = ops[k];
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        if (w[6:0] == 7'h33) begin
            k = $urandom_range(0, 2);
            w[31:25] = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'h01;
        end
        if (w[6:0] == 7'h73) w[14:12] = sys_f3[$urandom_range(0, 6)];
        return w;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            in_instr   = gen_instr();
            in_pc      = {$urandom, $urandom} & ~64'h3;
            #1;
            n_tests++; if ({a_in_ready, b_in_ready} !== {2{model_ready()}})
                begin n_fail++; $display("FAIL rnd_in_ready[%0d] got=%b%b exp=%b", i, a_in_ready, b_in_ready, model_ready()); end
            tick();
            n_tests++; if (obs_a() !== exp_a) begin n_fail++; $display("FAIL rnd_a[%0d] instr=%h got=%h exp=%h", i, in_instr, obs_a(), exp_a); end
            n_tests++; if (obs_b() !== exp_b) begin n_fail++; $display("FAIL rnd_b[%0d] instr=%h got=%h exp=%h", i, in_instr, obs_b(), exp_b); end
        end
        rst = 0; in_valid = 0; flush = 0; ex_memread = 0; out_ready = 1;
    endtask

    initial begin
        test_reset();
        test_alu_imm();
        test_load_store();
        test_load_use();
        test_backpressure_flush();
        test_csr_muldiv();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
